// File: rtl/dmem_wait.sv
// Multi-cycle RV32I data memory: one load/store at a time, LATENCY wait cycles, then a one-cycle rvalid.
// Faulting accesses (misaligned, out of range, illegal funct3) return err=1, RD=0 and leave memory untouched.
module dmem_wait #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        rvalid,
  output logic        err,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q, wd_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [29:0] idx;
  logic [1:0]  lane;
  logic [AW-1:0] widx;
  logic        in_range, legal, align_ok, fault;
  logic [31:0] rdata, load_v, wdata;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Address decode; a base above A wraps to a huge offset and lands out of range.
  always_comb begin
    off      = a_q - BASE_ADDR;
    idx      = off[31:2];
    lane     = off[1:0];
    widx     = idx[AW-1:0];
    in_range = ({2'b00, idx} < 32'(DEPTH_WORDS));
    rdata    = in_range ? mem[widx] : 32'h0;
  end

  always_comb begin
    legal    = 1'b0;
    align_ok = 1'b0;
    case (f3_q)
      3'b000: begin legal = 1'b1;  align_ok = 1'b1;          end
      3'b001: begin legal = 1'b1;  align_ok = ~lane[0];      end
      3'b010: begin legal = 1'b1;  align_ok = (lane == 2'b00); end
      3'b100: begin legal = ~we_q; align_ok = 1'b1;          end
      3'b101: begin legal = ~we_q; align_ok = ~lane[0];      end
      default: begin legal = 1'b0; align_ok = 1'b0;          end
    endcase
    fault = ~legal | ~align_ok | ~in_range;
  end

  always_comb begin
    byte_v = 8'(rdata >> {lane, 3'b000});
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    load_v = 32'h0;
    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b010:  load_v = rdata;
      3'b100:  load_v = {24'h0, byte_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = 32'h0;
    endcase
  end

  // Read-modify-write merge so sb/sh leave the other bytes intact.
  always_comb begin
    wdata = rdata;
    case (f3_q)
      3'b000:  wdata[{lane, 3'b000} +: 8] = wd_q[7:0];
      3'b001:  if (lane[1]) wdata[31:16] = wd_q[15:0];
               else         wdata[15:0]  = wd_q[15:0];
      3'b010:  wdata = wd_q;
      default: wdata = rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset must release the pipeline immediately, even with req held high.
    if (rst) stall = 1'b0;
  end

  assign rvalid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      RD    <= 32'h0;
      err   <= 1'b0;
      we_q  <= 1'b0;
      f3_q  <= 3'b000;
      a_q   <= 32'h0;
      wd_q  <= 32'h0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req) begin
          we_q <= WE;
          f3_q <= funct3;
          a_q  <= A;
          wd_q <= WD;
          cnt  <= 4'(LATENCY - 1);
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            RD  <= (fault || we_q) ? 32'h0 : load_v;
            err <= fault;
            if (!fault && we_q) mem[widx] <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Scoreboarded bench for dmem_wait: a default instance and a small offset-base LATENCY=1 instance,
// checked against a byte-addressed reference memory.
module tb_dmem_wait;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0, we0, rv0, er0, st0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;
  logic        req1, we1, rv1, er1, st1;
  logic [2:0]  f31;
  logic [31:0] a1, wd1, rd1;

  dmem_wait dut0 (
    .clk(clk), .rst(rst), .req(req0), .WE(we0), .funct3(f30), .A(a0), .WD(wd0),
    .RD(rd0), .rvalid(rv0), .err(er0), .stall(st0)
  );

  dmem_wait #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .WE(we1), .funct3(f31), .A(a1), .WD(wd1),
    .RD(rd1), .rvalid(rv1), .err(er1), .stall(st1)
  );

  typedef struct { logic [31:0] rd; logic e; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] bmem [longint];

  int checks = 0;
  int fails  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as independent bytes, access rules applied directly.
  task automatic model(int d, bit w, bit [2:0] f, bit [31:0] addr, bit [31:0] wd,
                       output bit [31:0] rd, output bit e);
    bit [31:0] base  = (d == 0) ? 32'h0 : 32'h1000;
    longint    depth = (d == 0) ? 1024 : 16;
    bit [31:0] off   = addr - base;
    int        size  = 0;
    bit        sgn   = 0;
    bit [31:0] v     = 0;
    longint    k;
    if (!w) begin
      case (f)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end else begin
      case (f)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    e  = (size == 0) || (longint'(off / 4) >= depth) || ((off % size) != 0);
    rd = 0;
    if (e) return;
    for (int i = 0; i < size; i++) begin
      k = (longint'(d) << 32) + longint'(off) + i;
      if (w) bmem[k] = wd[8*i +: 8];
      else   v |= 32'(bmem.exists(k) ? bmem[k] : 8'h0) << (8*i);
    end
    if (!w) begin
      if (sgn && size == 1 && v[7])  v |= 32'hFFFF_FF00;
      if (sgn && size == 2 && v[15]) v |= 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic set_in(int d, bit r, bit w, bit [2:0] f, bit [31:0] addr, bit [31:0] wd);
    if (d == 0) begin req0 = r; we0 = w; f30 = f; a0 = addr; wd0 = wd; end
    else        begin req1 = r; we1 = w; f31 = f; a1 = addr; wd1 = wd; end
  endtask

  function automatic logic st_of(int d);
    return (d == 0) ? st0 : st1;
  endfunction
  function automatic logic rv_of(int d);
    return (d == 0) ? rv0 : rv1;
  endfunction

  task automatic push(int d, bit [31:0] rd, bit e);
    exp_t x;
    x.rd = rd;
    x.e  = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Issues one request, scrambles the inputs after capture, checks stall length and response timing.
  task automatic drive(int d, bit w, bit [2:0] f, bit [31:0] addr, bit [31:0] wd);
    int n = 1;
    bit got = 0;
    int lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    set_in(d, 1'b1, w, f, addr, wd);
    #1 chk("stall_cycle0", 32'(st_of(d)), 32'd1);
    @(posedge clk);
    #1 set_in(d, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rv_of(d))      got = 1;
      else if (st_of(d)) n++;
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(n), 32'(lat + 1));
    if (got) chk("stall_in_resp", 32'(st_of(d)), 32'd0);
  endtask

  task automatic dir(int d, bit w, bit [2:0] f, bit [31:0] addr, bit [31:0] wd,
                     bit [31:0] exp_rd, bit exp_e);
    bit [31:0] mrd;
    bit        me;
    model(d, w, f, addr, wd, mrd, me);
    push(d, exp_rd, exp_e);
    drive(d, w, f, addr, wd);
  endtask

  task automatic rnd(int d, bit w, bit [2:0] f, bit [31:0] addr, bit [31:0] wd);
    bit [31:0] mrd;
    bit        me;
    model(d, w, f, addr, wd, mrd, me);
    push(d, mrd, me);
    drive(d, w, f, addr, wd);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rv0) begin
      if (q0.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_rvalid0: got rvalid with no request pending at %0t", $time);
      end else begin
        x = q0.pop_front();
        chk("rd0", rd0, x.rd);
        chk("err0", 32'(er0), 32'(x.e));
      end
    end
    if (rv1) begin
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_rvalid1: got rvalid with no request pending at %0t", $time);
      end else begin
        x = q1.pop_front();
        chk("rd1", rd1, x.rd);
        chk("err1", 32'(er1), 32'(x.e));
      end
    end
  end

  function automatic bit [31:0] rnd_addr(int d);
    bit [31:0] base = (d == 0) ? 32'h0 : 32'h1000;
    bit [31:0] top  = (d == 0) ? 32'h1000 : 32'h40;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5, 6: return base + 32'($urandom_range(0, 63));
      7:       return base + top - 32'd4 + 32'($urandom_range(0, 7));
      8:       return $urandom;
      default: return base - 32'd4 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);

    // Reset with req held high.
    rst = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    chk("rst_stall0", 32'(st0), 32'd0);
    chk("rst_rvalid0", 32'(rv0), 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_err0", 32'(er0), 32'd0);
    chk("rst_stall1", 32'(st1), 32'd0);
    @(posedge clk);
    #1 chk("rst_stall0_edge", 32'(st0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;

    dir(0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0);
    dir(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    dir(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    dir(0, 1, 3'b000, 32'h13, 32'h00000080, 32'h0, 0);
    dir(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    dir(0, 0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
    dir(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 0);
    dir(0, 0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 0);
    dir(0, 0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);

    dir(0, 0, 3'b001, 32'h11, 32'h0, 32'h0, 1);
    dir(0, 1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1);
    dir(0, 0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    dir(0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
    dir(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    dir(0, 1, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    dir(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 1);

    dir(1, 1, 3'b010, 32'h103C, 32'hA5A5A5A5, 32'h0, 0);
    dir(1, 0, 3'b010, 32'h103C, 32'h0, 32'hA5A5A5A5, 0);
    dir(1, 0, 3'b010, 32'h1040, 32'h0, 32'h0, 1);
    dir(1, 0, 3'b010, 32'h0FFC, 32'h0, 32'h0, 1);

    // Reset in the middle of a store: no response, memory stays cleared.
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
    @(posedge clk);
    #1 set_in(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("busy_stall", 32'(st0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(st0), 32'd0);
    chk("midrst_rvalid", 32'(rv0), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bmem.delete();
    dir(0, 0, 3'b010, 32'h20, 32'h0, 32'h0, 0);
    dir(0, 0, 3'b010, 32'h10, 32'h0, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      int d = i % 2;
      rnd(d, 1'($urandom), 3'($urandom), rnd_addr(d), $urandom);
    end

    @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dmem_wait.md
Name: dmem_wait

Overview:
Parametrised multi-cycle data memory. It is the next-generation replacement for the single-cycle data memory in the pipelined core. It takes one load/store request at a time, performs RV32I byte/half/word access with sign or zero extension, and adds a configurable access latency. While a request is outstanding it drives a stall to the pipeline. It flags misaligned, out-of-range and illegal-funct3 accesses instead of corrupting memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; valid range 1..65536.
LATENCY, 2, wait cycles before the access is performed; valid range 1..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-aligned.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  access request from MEM stage; sampled only in IDLE
WE  input  1  1 = store, 0 = load; captured with req
funct3  input  3  RV32I size/sign code; captured with req
A  input  32  byte address; captured with req
WD  input  32  store data, right-aligned; captured with req
RD  output  32  load result, extended; valid while rvalid=1
rvalid  output  1  one-cycle completion pulse, for loads and stores
err  output  1  access faulted; valid while rvalid=1
stall  output  1  pipeline hold request

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0, RD=0, rvalid=0, err=0, all memory words=0. Storage is a register array so that it can be cleared.
- Reset mid-operation aborts the access. A pending store is discarded and memory stays cleared. stall drops the moment rst asserts.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - stall = req (combinational).
  - On a clock edge with req=1: capture WE, funct3, A and WD; set cnt=LATENCY-1; go to BUSY.
- BUSY:
  - stall=1.
  - If cnt≠0: decrement cnt.
  - If cnt=0: perform the access on this edge, register RD and err, go to RESP.
- RESP:
  - stall=0, rvalid=1, RD and err hold the registered values.
  - Next state is always IDLE. req is ignored in RESP; the pipeline advances at the end of RESP.
- Timing: for a request asserted in cycle 0, stall is high in cycles 0..LATENCY and rvalid is high in cycle LATENCY+1. Back-to-back requests therefore take LATENCY+2 cycles each.
- Address decode:
  - off = A - BASE_ADDR (32-bit wrap).
  - idx = off[31:2]; lane = off[1:0].
  - Out of range when idx ≥ DEPTH_WORDS; A below BASE_ADDR wraps and is also out of range.
- Legal loads:
  - 000 lb, sign-extend byte at lane.
  - 001 lh, sign-extend half at lane[1].
  - 010 lw.
  - 100 lbu, zero-extend byte.
  - 101 lhu, zero-extend half.
- Legal stores:
  - 000 sb: WD[7:0] into byte lane; other bytes unchanged.
  - 001 sh: WD[15:0] into half lane[1].
  - 010 sw: full word.
- Fault conditions, any of which sets err=1, forces RD=0 and writes no memory:
  - half access with lane[0]=1;
  - word access with lane≠0;
  - out of range;
  - illegal funct3 (loads 011/11x; stores 011 and above).
- Stores return RD=0 and err=0 on success.
- Memory contents change only on the BUSY cnt=0 edge of a non-faulting store.
- WD, A and funct3 changing after the request is accepted have no effect, because they were captured.

Test Plan:
1. Reset check: assert rst with req=1 → stall=0, rvalid=0, RD=0, err=0. Then lw A=0x0 → RD=0x00000000 at rvalid, err=0.
2. Latency check (LATENCY=2): sw A=0x10 WD=0xDEADBEEF, then lw A=0x10 → each request shows stall high for 3 cycles and rvalid in the 4th, RD=0xDEADBEEF.
3. Byte store and extension: after test 2, sb A=0x13 WD=0x00000080.
   - lb 0x13 → 0xFFFFFF80.
   - lbu 0x13 → 0x00000080.
   - lh 0x12 → 0xFFFF80AD.
   - lhu 0x12 → 0x000080AD.
   - lw 0x10 → 0x80ADBEEF.
4. Fault handling:
   - lh A=0x11 → err=1, RD=0.
   - sw A=0x12 WD=0xFFFFFFFF → err=1; a following lw 0x10 is still 0x80ADBEEF.
   - lw A=4*DEPTH_WORDS → err=1.
   - funct3=011 load → err=1.
5. Reset mid-store: sw A=0x20 WD=0x12345678, assert rst during BUSY → stall drops immediately, no rvalid. After release, lw 0x20 → 0x00000000.
6. Parameter sweep with LATENCY=1, BASE_ADDR=0x1000, DEPTH_WORDS=16:
   - sw 0x103C WD=0xA5A5A5A5 then lw 0x103C → stall 2 cycles, RD=0xA5A5A5A5.
   - lw 0x1040 → err=1.
   - lw 0x0FFC → err=1.
